// File: rtl/i2c_target_receiver.sv
// I2C target receive engine: synchronises SCL/SDA, detects START/STOP, matches a
// 7-bit address on write transfers, ACKs each byte and strobes received data out.
module i2c_target_receiver #(
    parameter logic [6:0] ADDRESS     = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       ClockI2C,
    input  logic       Reset,
    input  logic       Scl,
    input  logic       SdaIn,
    output logic       SdaPullLow,
    output logic [7:0] DataOut,
    output logic       DataValid,
    output logic       Addressed,
    output logic       BusBusy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDRESS,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_IGNORE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic [7:0]             shift_q, shift_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic                   pull_q, pull_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   addressed_q, addressed_d;
    logic                   busy_q, busy_d;

    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] shifted;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & ~sda_s & sda_prev_q;
    assign stop_det  = scl_s & sda_s & ~sda_prev_q;
    assign shifted   = {shift_q[6:0], sda_s};

    always_comb begin
        state_d     = state_q;
        scl_sync_d  = {scl_sync_q[SYNC_STAGES-2:0], Scl};
        sda_sync_d  = {sda_sync_q[SYNC_STAGES-2:0], SdaIn};
        scl_prev_d  = scl_s;
        sda_prev_d  = sda_s;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        pull_d      = pull_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        addressed_d = addressed_q;
        busy_d      = busy_q;

        // Bus conditions override any bit activity seen in the same cycle.
        if (stop_det) begin
            state_d     = ST_IDLE;
            shift_d     = 8'h00;
            bit_cnt_d   = 4'd0;
            pull_d      = 1'b0;
            addressed_d = 1'b0;
            busy_d      = 1'b0;
        end else if (start_det) begin
            state_d     = ST_ADDRESS;
            shift_d     = 8'h00;
            bit_cnt_d   = 4'd0;
            pull_d      = 1'b0;
            addressed_d = 1'b0;
            busy_d      = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: bit_cnt_d = 4'd0;
                ST_ADDRESS: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = shifted;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        // Reads are unsupported, so R/W=1 is treated like a mismatch.
                        if (bit_cnt_q == 4'd7 && (shifted[7:1] != ADDRESS || shifted[0]))
                            state_d = ST_IGNORE;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        state_d     = ST_ADDR_ACK;
                        pull_d      = 1'b1;
                        addressed_d = 1'b1;
                    end
                end
                ST_ADDR_ACK, ST_DATA_ACK: begin
                    if (scl_fall) begin
                        state_d   = ST_DATA;
                        pull_d    = 1'b0;
                        bit_cnt_d = 4'd0;
                    end
                end
                ST_DATA: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = shifted;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            data_d  = shifted;
                            valid_d = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        state_d = ST_DATA_ACK;
                        pull_d  = 1'b1;
                    end
                end
                ST_IGNORE: pull_d = 1'b0;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ClockI2C or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            shift_q     <= 8'h00;
            bit_cnt_q   <= 4'd0;
            pull_q      <= 1'b0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            addressed_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_prev_q  <= scl_prev_d;
            sda_prev_q  <= sda_prev_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            pull_q      <= pull_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            addressed_q <= addressed_d;
            busy_q      <= busy_d;
        end
    end

    assign SdaPullLow = pull_q;
    assign DataOut    = data_q;
    assign DataValid  = valid_q;
    assign Addressed  = addressed_q;
    assign BusBusy    = busy_q;

endmodule
